char_plotter: RTL and testbench
===============================

Name: char_plotter

Overview:
- Initiator side of the VGA adapter's pixel-plot interface (x, y, colour, writeEn).
- Renders one 8x8 glyph at a text cell, or clears the whole frame to a background colour, one pixel write per cycle.
- Sits between the text-editor control logic and the VGA wrapper; reads glyph bitmaps from an external synchronous font ROM.

Parameters:
- H_RES, 320, frame width in pixels; text columns = H_RES/8 (40).
- V_RES, 240, frame height in pixels; text rows = V_RES/8 (30).
- TRANSPARENT, 0, 1 = glyph background pixels are skipped (writeEn low), 0 = written with bg_colour.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous active-low reset.
- start  in  1  request glyph render; sampled only in IDLE.
- clear  in  1  request full-frame clear; sampled only in IDLE.
- char_code  in  7  ASCII code of glyph.
- col  in  6  text column, valid range 0..39.
- row  in  5  text row, valid range 0..29.
- fg_colour  in  3  foreground RGB.
- bg_colour  in  3  background RGB; also used for clear.
- glyph_addr  out  10  font ROM address {char_code, line[2:0]}.
- glyph_data  in  8  font ROM data, valid 1 cycle after glyph_addr; bit 7 = leftmost pixel.
- x  out  9  plot x to VGA wrapper.
- y  out  9  plot y to VGA wrapper.
- colour  out  3  plot colour.
- writeEn  out  1  plot strobe, one pixel per cycle high.
- busy  out  1  high from the cycle after an accepted request until done.
- done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset (async, any state): state=IDLE; x=0, y=0, colour=0, writeEn=0, busy=0, done=0, glyph_addr=0; in-flight operation abandoned, no further writes.
- Outputs x, y, colour, writeEn, done, busy are registered.
- IDLE: clear=1 takes priority over start. start with col>39 or row>29 is ignored (no busy, no done). An accepted request latches char_code, col, row, fg_colour, bg_colour; later input changes have no effect.
- Glyph render, per line L=0..7:
  - FETCH (1 cycle): glyph_addr={char_code, L}.
  - LATCH (1 cycle): glyph_data captured into an 8-bit line register.
  - PLOT (8 cycles, p=0..7): x=col*8+p, y=row*8+L, colour = line[7-p] ? fg : bg.
  - writeEn=1, except writeEn=0 for clear bits when TRANSPARENT=1.
- Render timing: 10 cycles per line, 80 cycles per glyph. done pulses in the cycle after the last PLOT; busy falls in the same cycle. Return to IDLE; a new start is accepted the next cycle.
- Clear: raster sweep, y outer 0..V_RES-1, x inner 0..H_RES-1. colour=bg_colour, writeEn=1 every cycle, H_RES*V_RES cycles (76800). x wraps 319->0 with y incrementing. done pulses after pixel (319,239).
- start or clear while busy: ignored, not queued.
- writeEn is 0 in every non-PLOT/non-CLEAR cycle. x and y hold their last values when writeEn=0.
- Arithmetic: col*8 and row*8 are formed by a 3-bit left shift into 9 bits; maximum values are x=319 and y=239, with no overflow.

Test Plan:
- Reset mid-render: assert reset at render cycle 37 -> writeEn=0 and busy=0 immediately; no writes after; next start accepted.
- Render 'A' (0x41) at col=2,row=3, fg=3'b111, bg=3'b000, ROM line0=8'b0001_1000 -> first write x=16,y=24,colour=0 at cycle 3 after accept; x=19/20 colour=7; last write x=23,y=31; exactly 64 writes; done at cycle 81.
- TRANSPARENT=1, same glyph -> writes only where ROM bits=1; count equals popcount of the 8 ROM lines.
- start and clear together, bg=3'b001 -> clear wins: 76800 writes, all colour=1, first (0,0), last (319,239), (319,0) followed by (0,1); start is dropped.
- start with col=40 or row=30 -> busy stays 0, no writeEn, no done; a following start with col=39,row=29 writes x 312..319, y 232..239.
- Second start while busy, with a different char_code -> ignored; glyph_addr shows only the first char's code; exactly one done pulse.

Source files
------------

// File: rtl/char_plotter.sv
// char_plotter
//   Drives the VGA adapter's pixel-plot interface. Either renders one 8x8
//   glyph at a text cell (fetching each bitmap line from an external
//   synchronous font ROM) or clears the whole frame to a background colour.
//   One pixel write per cycle.
//
// Ports
//   CLOCK_50, reset      clock (rising edge), async active-low reset
//   start, clear         operation requests, sampled only while idle
//   char_code, col, row  glyph and text cell (col < H_RES/8, row < V_RES/8)
//   fg_colour, bg_colour glyph colours; bg_colour also used by clear
//   glyph_addr           font ROM address {char_code, line}
//   glyph_data           font ROM data, one cycle after glyph_addr, bit 7 = left
//   x, y, colour, writeEn  registered plot outputs
//   busy, done           operation in progress / one-cycle completion pulse
module char_plotter #(
   parameter int H_RES       = 320,
   parameter int V_RES       = 240,
   parameter bit TRANSPARENT = 1'b0
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic       clear,
   input  logic [6:0] char_code,
   input  logic [5:0] col,
   input  logic [4:0] row,
   input  logic [2:0] fg_colour,
   input  logic [2:0] bg_colour,
   output logic [9:0] glyph_addr,
   input  logic [7:0] glyph_data,
   output logic [8:0] x,
   output logic [8:0] y,
   output logic [2:0] colour,
   output logic       writeEn,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_PLOT, S_CLEAR} state_t;

   localparam logic [8:0] X_MAX  = 9'(H_RES - 1);
   localparam logic [8:0] Y_MAX  = 9'(V_RES - 1);
   localparam logic [5:0] N_COLS = 6'(H_RES / 8);
   localparam logic [4:0] N_ROWS = 5'(V_RES / 8);

   state_t     state, state_n;
   logic [6:0] chr_q, chr_n;
   logic [5:0] col_q, col_n;
   logic [4:0] row_q, row_n;
   logic [2:0] fg_q, fg_n, bg_q, bg_n;
   logic [7:0] line_q, line_n;   // left-shifting copy of the current bitmap line
   logic [2:0] pix_q, pix_n;
   logic [2:0] ln_q, ln_n;
   logic [9:0] addr_n;
   logic [8:0] x_n, y_n;
   logic [2:0] colour_n;
   logic       we_n, busy_n, done_n;

   // pixel produced this cycle (glyph render only)
   logic       plot_now, pix_bit;
   logic [2:0] pix_idx;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         chr_q      <= '0;
         col_q      <= '0;
         row_q      <= '0;
         fg_q       <= '0;
         bg_q       <= '0;
         line_q     <= '0;
         pix_q      <= '0;
         ln_q       <= '0;
         glyph_addr <= '0;
         x          <= '0;
         y          <= '0;
         colour     <= '0;
         writeEn    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         chr_q      <= chr_n;
         col_q      <= col_n;
         row_q      <= row_n;
         fg_q       <= fg_n;
         bg_q       <= bg_n;
         line_q     <= line_n;
         pix_q      <= pix_n;
         ln_q       <= ln_n;
         glyph_addr <= addr_n;
         x          <= x_n;
         y          <= y_n;
         colour     <= colour_n;
         writeEn    <= we_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

   always_comb begin
      state_n  = state;
      chr_n    = chr_q;
      col_n    = col_q;
      row_n    = row_q;
      fg_n     = fg_q;
      bg_n     = bg_q;
      line_n   = line_q;
      pix_n    = pix_q;
      ln_n     = ln_q;
      addr_n   = glyph_addr;
      x_n      = x;
      y_n      = y;
      colour_n = colour;
      we_n     = 1'b0;
      busy_n   = busy;
      done_n   = 1'b0;
      plot_now = 1'b0;
      pix_bit  = 1'b0;
      pix_idx  = 3'd0;

      case (state)
         S_IDLE: begin
            if (clear) begin
               bg_n     = bg_colour;
               x_n      = '0;
               y_n      = '0;
               colour_n = bg_colour;
               we_n     = 1'b1;
               busy_n   = 1'b1;
               state_n  = S_CLEAR;
            end else if (start && col < N_COLS && row < N_ROWS) begin
               chr_n   = char_code;
               col_n   = col;
               row_n   = row;
               fg_n    = fg_colour;
               bg_n    = bg_colour;
               ln_n    = 3'd0;
               addr_n  = {char_code, 3'd0};
               busy_n  = 1'b1;
               state_n = S_FETCH;
            end
         end
         // ROM is sampling glyph_addr this cycle
         S_FETCH: state_n = S_LATCH;
         // glyph_data is valid now; the first pixel is taken straight from it
         // so the registered plot outputs line up with the PLOT cycles
         S_LATCH: begin
            line_n   = {glyph_data[6:0], 1'b0};
            pix_n    = 3'd0;
            plot_now = 1'b1;
            pix_bit  = glyph_data[7];
            pix_idx  = 3'd0;
            state_n  = S_PLOT;
         end
         S_PLOT: begin
            if (pix_q == 3'd7) begin
               if (ln_q == 3'd7) begin
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  ln_n    = ln_q + 3'd1;
                  addr_n  = {chr_q, ln_q + 3'd1};
                  state_n = S_FETCH;
               end
            end else begin
               pix_n    = pix_q + 3'd1;
               line_n   = {line_q[6:0], 1'b0};
               plot_now = 1'b1;
               pix_bit  = line_q[7];
               pix_idx  = pix_q + 3'd1;
            end
         end
         S_CLEAR: begin
            if (x == X_MAX && y == Y_MAX) begin
               busy_n  = 1'b0;
               done_n  = 1'b1;
               state_n = S_IDLE;
            end else begin
               we_n = 1'b1;
               if (x == X_MAX) begin
                  x_n = '0;
                  y_n = y + 9'd1;
               end else begin
                  x_n = x + 9'd1;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase

      // skipped transparent pixels leave x/y/colour untouched
      if (plot_now) begin
         we_n = pix_bit | !TRANSPARENT;
         if (we_n) begin
            x_n      = {col_q, pix_idx};
            y_n      = {1'b0, row_q, ln_q};
            colour_n = pix_bit ? fg_q : bg_q;
         end
      end
   end

endmodule

// File: tb/tb_char_plotter.sv
// tb_char_plotter
//   Two instances share all inputs: dut0 opaque, dut1 TRANSPARENT=1. Each has
//   its own synchronous font ROM model. Table of glyph requests plus hand
//   sequences for reset mid-render, clear, and requests while busy.
module tb_char_plotter;

   logic       clk = 1'b0;
   logic       rst_n, start, clear;
   logic [6:0] char_code;
   logic [5:0] col;
   logic [4:0] row;
   logic [2:0] fg, bg;
   logic [9:0] ga0, ga1;
   logic [7:0] gd0, gd1;
   logic [8:0] x0, y0, x1, y1;
   logic [2:0] c0, c1;
   logic       we0, we1, busy0, busy1, done0, done1;

   always #5 clk = ~clk;

   char_plotter #(.H_RES(320), .V_RES(240), .TRANSPARENT(1'b0)) dut0 (
      .CLOCK_50(clk), .reset(rst_n), .start(start), .clear(clear),
      .char_code(char_code), .col(col), .row(row), .fg_colour(fg), .bg_colour(bg),
      .glyph_addr(ga0), .glyph_data(gd0), .x(x0), .y(y0), .colour(c0),
      .writeEn(we0), .busy(busy0), .done(done0));

   char_plotter #(.H_RES(320), .V_RES(240), .TRANSPARENT(1'b1)) dut1 (
      .CLOCK_50(clk), .reset(rst_n), .start(start), .clear(clear),
      .char_code(char_code), .col(col), .row(row), .fg_colour(fg), .bg_colour(bg),
      .glyph_addr(ga1), .glyph_data(gd1), .x(x1), .y(y1), .colour(c1),
      .writeEn(we1), .busy(busy1), .done(done1));

   logic [7:0] rom [1024];
   always @(posedge clk) begin
      gd0 <= rom[ga0];
      gd1 <= rom[ga1];
   end

   int n_cmp = 0, n_bad = 0;
   int wr0, wr1, bad0, bad1, dn0, dn1, first_cyc, done_cyc, busy_c, addr_bad;

   typedef struct {
      logic [6:0] ch;
      logic [5:0] cc;
      logic [4:0] rr;
      logic [2:0] f, b;
      bit         ok;
   } vec_t;
   vec_t vt[6];

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic rbit(input logic [6:0] ch, input int k);
      logic [7:0] v;
      v = rom[{ch, 3'(k / 8)}];
      return v[7 - (k % 8)];
   endfunction

   function automatic int popcnt(input logic [6:0] ch);
      int n = 0;
      for (int k = 0; k < 64; k++) n += int'(rbit(ch, k));
      return n;
   endfunction

   // Issue a glyph start and observe ncyc cycles; cycle t is the t-th cycle
   // after the accept cycle. At inj_t a conflicting start+clear is injected.
   task automatic run_glyph(input logic [6:0] ch, input logic [5:0] cc, input logic [4:0] rr,
                            input logic [2:0] f, input logic [2:0] b, input int ncyc, input int inj_t);
      int j0, j1, ex, ey;
      wr0 = 0; wr1 = 0; bad0 = 0; bad1 = 0; dn0 = 0; dn1 = 0;
      first_cyc = -1; done_cyc = -1; busy_c = 0; addr_bad = 0;
      j0 = 0; j1 = 0;
      @(negedge clk);
      start = 1'b1; clear = 1'b0; char_code = ch; col = cc; row = rr; fg = f; bg = b;
      for (int t = 1; t <= ncyc; t++) begin
         @(negedge clk);
         if (t == 1) start = 1'b0;
         if (t == inj_t) begin
            start = 1'b1; clear = 1'b1; char_code = 7'h55; col = 6'd0; row = 5'd0;
            fg = 3'd2; bg = 3'd5;
         end
         if (t == inj_t + 1) begin start = 1'b0; clear = 1'b0; end
         if (busy0) busy_c++;
         if (busy0 && ga0[9:3] != ch) addr_bad++;
         if (done0) begin dn0++; done_cyc = t; end
         if (done1) dn1++;
         if (we0) begin
            if (wr0 == 0) first_cyc = t;
            if (j0 < 64) begin
               ex = int'(cc) * 8 + j0 % 8;
               ey = int'(rr) * 8 + j0 / 8;
               if (int'(x0) != ex || int'(y0) != ey || c0 != (rbit(ch, j0) ? f : b)) bad0++;
            end else bad0++;
            j0++; wr0++;
         end
         if (we1) begin
            while (j1 < 64 && !rbit(ch, j1)) j1++;
            if (j1 < 64) begin
               ex = int'(cc) * 8 + j1 % 8;
               ey = int'(rr) * 8 + j1 / 8;
               if (int'(x1) != ex || int'(y1) != ey || c1 != f) bad1++;
            end else bad1++;
            j1++; wr1++;
         end
      end
   endtask

   initial begin
      int k, cnt;
      logic [17:0] first_xy, last_xy;

      for (int i = 0; i < 1024; i++) rom[i] = 8'((i * 37) ^ 165);
      rom[{7'h41, 3'd0}] = 8'h18; rom[{7'h41, 3'd1}] = 8'h3C;
      rom[{7'h41, 3'd2}] = 8'h66; rom[{7'h41, 3'd3}] = 8'h66;
      rom[{7'h41, 3'd4}] = 8'h7E; rom[{7'h41, 3'd5}] = 8'h66;
      rom[{7'h41, 3'd6}] = 8'h66; rom[{7'h41, 3'd7}] = 8'h00;
      rom[{7'h23, 3'd0}] = 8'hFF; rom[{7'h23, 3'd1}] = 8'h00;

      vt[0] = '{7'h41, 6'd2,  5'd3,  3'd7, 3'd0, 1'b1};
      vt[1] = '{7'h23, 6'd39, 5'd29, 3'd5, 3'd2, 1'b1};
      vt[2] = '{7'h7F, 6'd0,  5'd0,  3'd1, 3'd6, 1'b1};
      vt[3] = '{7'h41, 6'd40, 5'd3,  3'd7, 3'd0, 1'b0};
      vt[4] = '{7'h41, 6'd5,  5'd30, 3'd7, 3'd0, 1'b0};
      vt[5] = '{7'h10, 6'd39, 5'd29, 3'd3, 3'd4, 1'b1};

      rst_n = 1'b0; start = 1'b0; clear = 1'b0; char_code = '0; col = '0; row = '0;
      fg = '0; bg = '0;
      #1;
      check("reset_state_opaque", int'({x0, y0, c0, we0, busy0, done0, ga0}), 0);
      check("reset_state_transp", int'({x1, y1, c1, we1, busy1, done1, ga1}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // table-driven glyph requests
      foreach (vt[i]) begin
         run_glyph(vt[i].ch, vt[i].cc, vt[i].rr, vt[i].f, vt[i].b, 90, 0);
         if (vt[i].ok) begin
            check($sformatf("v%0d_writes", i), wr0, 64);
            check($sformatf("v%0d_pixels", i), bad0, 0);
            check($sformatf("v%0d_first_cycle", i), first_cyc, 3);
            check($sformatf("v%0d_done_cycle", i), done_cyc, 81);
            check($sformatf("v%0d_done_count", i), dn0, 1);
            check($sformatf("v%0d_busy_cycles", i), busy_c, 80);
            check($sformatf("v%0d_transp_writes", i), wr1, popcnt(vt[i].ch));
            check($sformatf("v%0d_transp_pixels", i), bad1, 0);
            check($sformatf("v%0d_transp_done", i), dn1, 1);
            check($sformatf("v%0d_addr", i), addr_bad, 0);
         end else begin
            check($sformatf("v%0d_rej_writes", i), wr0 + wr1, 0);
            check($sformatf("v%0d_rej_busy", i), busy_c, 0);
            check($sformatf("v%0d_rej_done", i), dn0 + dn1, 0);
         end
      end

      // reset in the middle of a render
      @(negedge clk);
      start = 1'b1; char_code = 7'h41; col = 6'd2; row = 5'd3; fg = 3'd7; bg = 3'd0;
      for (int t = 1; t <= 37; t++) begin
         @(negedge clk);
         if (t == 1) start = 1'b0;
      end
      check("midrender_busy_before", int'(busy0), 1);
      rst_n = 1'b0;
      #1;
      check("midrender_reset_outputs", int'({we0, busy0, done0, we1, busy1, done1}), 0);
      cnt = 0;
      repeat (3) begin @(negedge clk); cnt += int'(we0) + int'(we1) + int'(busy0) + int'(done0); end
      rst_n = 1'b1;
      repeat (20) begin @(negedge clk); cnt += int'(we0) + int'(we1) + int'(busy0) + int'(done0); end
      check("midrender_activity_after", cnt, 0);
      run_glyph(7'h41, 6'd2, 5'd3, 3'd7, 3'd0, 90, 0);
      check("after_reset_writes", wr0, 64);
      check("after_reset_done_cycle", done_cyc, 81);

      // start or clear while busy must be dropped
      run_glyph(7'h41, 6'd2, 5'd3, 3'd7, 3'd0, 95, 20);
      check("busy_ignore_writes", wr0, 64);
      check("busy_ignore_pixels", bad0, 0);
      check("busy_ignore_addr", addr_bad, 0);
      check("busy_ignore_done", dn0, 1);
      check("busy_ignore_transp", bad1, 0);

      // clear and start together: clear wins
      @(negedge clk);
      start = 1'b1; clear = 1'b1; bg = 3'd1; fg = 3'd7; char_code = 7'h41; col = 6'd2; row = 5'd3;
      k = 0; bad0 = 0; wr1 = 0; dn0 = 0; done_cyc = -1; first_xy = '1; last_xy = '1;
      for (int t = 1; t <= 76810; t++) begin
         @(negedge clk);
         if (t == 1) begin start = 1'b0; clear = 1'b0; bg = 3'd6; end
         if (we0) begin
            if (int'(x0) != k % 320 || int'(y0) != k / 320 || c0 != 3'd1) bad0++;
            if (k == 0) first_xy = {x0, y0};
            last_xy = {x0, y0};
            k++;
         end
         if (we1) wr1++;
         if (done0) begin dn0++; done_cyc = t; end
      end
      check("clear_writes", k, 76800);
      check("clear_raster", bad0, 0);
      check("clear_first_xy", int'(first_xy), 0);
      check("clear_last_xy", int'(last_xy), int'({9'd319, 9'd239}));
      check("clear_done_cycle", done_cyc, 76801);
      check("clear_done_count", dn0, 1);
      check("clear_transp_writes", wr1, 76800);
      cnt = 0;
      repeat (50) begin @(negedge clk); cnt += int'(we0) + int'(busy0) + int'(done0); end
      check("clear_start_dropped", cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
